// File: rtl/sata_reset_pkg.sv
// rtl/sata_reset_pkg.sv - shared state encoding and sizing helper for the SATA reset sequencer
// Contents:
//   seq_state_t  - sequencer FSM state encoding (codes 5-7 unused)
//   retry_cnt_w  - width of the retry counter for a given MAX_RETRY
package sata_reset_pkg;

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    TX_RST    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } seq_state_t;

  // Enough bits to hold 0..MAX_RETRY; never narrower than one bit.
  function automatic int retry_cnt_w(input int max_retry);
    return (max_retry < 1) ? 1 : $clog2(max_retry + 1);
  endfunction

endpackage

// File: rtl/sata_lock_qualifier.sv
// rtl/sata_lock_qualifier.sv - all-enabled-lanes-locked reduction with stability counter
// Ports:
//   i_clk, i_rst      - sequencer clock, asynchronous active-high reset
//   i_lane_en         - lane enable mask; disabled lanes count as locked
//   i_pll_lock        - per-lane PLL lock, already synchronised to i_clk
//   i_clr             - holds the stability counter at zero
//   o_all_lk          - at least one lane enabled and every enabled lane locked
//   o_qualified       - all_lk has held for STABLE_CYCLES consecutive cycles (this one included)
module sata_lock_qualifier #(
  parameter int NUM_LANES     = 1,
  parameter int STABLE_CYCLES = 1024,
  parameter int CNT_W         = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_LANES-1:0] i_lane_en,
  input  logic [NUM_LANES-1:0] i_pll_lock,
  input  logic                 i_clr,
  output logic                 o_all_lk,
  output logic                 o_qualified
);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [CNT_W-1:0] r_stab;
  logic             w_all_lk;

  // An all-masked lane set must not look "locked".
  assign w_all_lk = (|i_lane_en) && (&(i_pll_lock | ~i_lane_en));

  // Saturates at the last value so a stalled consumer cannot wrap it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stab <= '0;
    end else if (i_clr || !w_all_lk) begin
      r_stab <= '0;
    end else if (r_stab != STABLE_LAST) begin
      r_stab <= r_stab + CNT_W'(1);
    end
  end

  assign o_all_lk    = w_all_lk;
  assign o_qualified = w_all_lk && (r_stab == STABLE_LAST);

endmodule

// File: rtl/sata_reset_sequencer.sv
// rtl/sata_reset_sequencer.sv - multi-lane PLL/GT reset and bring-up sequencer with timeout/retry
// Ports:
//   i_clk, i_rst      - refclk-domain clock, asynchronous active-high reset
//   i_lane_en         - lane enable mask (disabled lanes ignored for lock, held in TX reset)
//   i_pll_lock        - per-lane PLL lock, synchronised to i_clk
//   i_retry_req       - single-cycle pulse, leaves FAIL
//   o_pll_reset       - PLL reset to the GT
//   o_gt_tx_reset     - per-lane GTTXRESET
//   o_tx_userrdy      - per-lane TXUSERRDY
//   o_core_ready      - high only in RUN
//   o_fail            - sequencer is in FAIL
//   o_lock_lost       - one-cycle pulse when an enabled lane loses lock in RUN
//   o_retry_cnt       - timeout attempts in the current bring-up
//   o_state           - encoded FSM state for debug
module sata_reset_sequencer
  import sata_reset_pkg::*;
#(
  parameter int NUM_LANES           = 1,
  parameter int HOLD_CYCLES         = 6000000,
  parameter int LOCK_TIMEOUT_CYCLES = 600000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int TX_RST_CYCLES       = 64,
  parameter int MAX_RETRY           = 3,
  parameter int CNT_W               = 32
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [NUM_LANES-1:0]                i_lane_en,
  input  logic [NUM_LANES-1:0]                i_pll_lock,
  input  logic                                i_retry_req,
  output logic                                o_pll_reset,
  output logic [NUM_LANES-1:0]                o_gt_tx_reset,
  output logic [NUM_LANES-1:0]                o_tx_userrdy,
  output logic                                o_core_ready,
  output logic                                o_fail,
  output logic                                o_lock_lost,
  output logic [retry_cnt_w(MAX_RETRY)-1:0]   o_retry_cnt,
  output logic [2:0]                          o_state
);

  localparam int               RW           = retry_cnt_w(MAX_RETRY);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TX_LAST      = CNT_W'(TX_RST_CYCLES - 1);

  seq_state_t            r_state, w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [RW-1:0]         r_retry, w_retry_next;
  logic                  w_all_lk, w_qualified, w_any_lost;
  logic                  w_pll_reset, w_core_ready, w_fail, w_lock_lost;
  logic [NUM_LANES-1:0]  w_gt_tx_reset, w_tx_userrdy;

  sata_lock_qualifier #(
    .NUM_LANES     (NUM_LANES),
    .STABLE_CYCLES (LOCK_STABLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_lock_qual (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_lane_en   (i_lane_en),
    .i_pll_lock  (i_pll_lock),
    .i_clr       (r_state != WAIT_LOCK),
    .o_all_lk    (w_all_lk),
    .o_qualified (w_qualified)
  );

  assign w_any_lost = |(i_lane_en & ~i_pll_lock);

  // Outputs are decoded from the next state so the registered copies line up
  // with the registered state.
  always_comb begin
    w_next        = r_state;
    w_retry_next  = r_retry;
    case (r_state)
      HOLD: begin
        if (r_cnt == HOLD_LAST) w_next = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (w_qualified) begin
          w_next = TX_RST;
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_retry_next = r_retry + RW'(1);
          w_next       = (w_retry_next == RW'(MAX_RETRY)) ? FAIL : HOLD;
        end
      end
      TX_RST: begin
        if (w_any_lost)             w_next = HOLD;
        else if (r_cnt == TX_LAST)  w_next = RUN;
      end
      RUN: begin
        if (w_any_lost) w_next = HOLD;
      end
      FAIL: begin
        if (i_retry_req) begin
          w_retry_next = '0;
          w_next       = HOLD;
        end
      end
      default: w_next = HOLD;
    endcase

    if (w_next == RUN) w_retry_next = '0;

    w_pll_reset   = (w_next == HOLD) || (w_next == FAIL);
    w_gt_tx_reset = '1;
    w_tx_userrdy  = '0;
    w_core_ready  = 1'b0;
    if (w_next == RUN) begin
      w_gt_tx_reset = ~i_lane_en;
      w_tx_userrdy  = i_lane_en;
      w_core_ready  = 1'b1;
    end
    w_fail      = (w_next == FAIL);
    w_lock_lost = (r_state == RUN) && w_any_lost;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= HOLD;
      r_cnt         <= '0;
      r_retry       <= '0;
      o_pll_reset   <= 1'b1;
      o_gt_tx_reset <= '1;
      o_tx_userrdy  <= '0;
      o_core_ready  <= 1'b0;
      o_fail        <= 1'b0;
      o_lock_lost   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_retry <= w_retry_next;
      // Counter restarts on every state entry; it only needs to run in timed states.
      if (w_next != r_state)
        r_cnt <= '0;
      else if (r_state == HOLD || r_state == WAIT_LOCK || r_state == TX_RST)
        r_cnt <= r_cnt + CNT_W'(1);
      o_pll_reset   <= w_pll_reset;
      o_gt_tx_reset <= w_gt_tx_reset;
      o_tx_userrdy  <= w_tx_userrdy;
      o_core_ready  <= w_core_ready;
      o_fail        <= w_fail;
      o_lock_lost   <= w_lock_lost;
    end
  end

  assign o_retry_cnt = r_retry;
  assign o_state     = r_state;

endmodule

// File: tb/tb_sata_reset_sequencer.sv
// tb/tb_sata_reset_sequencer.sv - directed vector bench for sata_reset_sequencer
module tb_sata_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] lane_en = 2'b11;
  logic [1:0] pll_lock = 2'b00;
  logic       retry_req = 1'b0;

  logic       pll_reset, core_ready, fail, lock_lost;
  logic [1:0] gt_tx_reset, tx_userrdy, retry_cnt;
  logic [2:0] state;
  logic [12:0] act;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sata_reset_sequencer #(
    .NUM_LANES(2), .HOLD_CYCLES(8), .LOCK_TIMEOUT_CYCLES(20),
    .LOCK_STABLE_CYCLES(4), .TX_RST_CYCLES(3), .MAX_RETRY(2), .CNT_W(8)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_lane_en(lane_en), .i_pll_lock(pll_lock),
    .i_retry_req(retry_req), .o_pll_reset(pll_reset), .o_gt_tx_reset(gt_tx_reset),
    .o_tx_userrdy(tx_userrdy), .o_core_ready(core_ready), .o_fail(fail),
    .o_lock_lost(lock_lost), .o_retry_cnt(retry_cnt), .o_state(state)
  );

  // {pll_reset, gt_tx_reset, tx_userrdy, core_ready, fail, lock_lost, retry_cnt, state}
  assign act = {pll_reset, gt_tx_reset, tx_userrdy, core_ready, fail, lock_lost, retry_cnt, state};

  typedef struct {
    bit          do_rst;
    int          n;
    logic [1:0]  en;
    logic [1:0]  lock;
    logic        retry;
    logic [12:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [12:0] s_hold(input logic [1:0] rc, input logic ll);
    return {1'b1, 2'b11, 2'b00, 1'b0, 1'b0, ll, rc, 3'd0};
  endfunction
  function automatic logic [12:0] s_wait(input logic [1:0] rc);
    return {1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, rc, 3'd1};
  endfunction
  function automatic logic [12:0] s_tx(input logic [1:0] rc);
    return {1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, rc, 3'd2};
  endfunction
  function automatic logic [12:0] s_run(input logic [1:0] gt, input logic [1:0] rdy);
    return {1'b0, gt, rdy, 1'b1, 1'b0, 1'b0, 2'd0, 3'd3};
  endfunction
  function automatic logic [12:0] s_fail(input logic [1:0] rc);
    return {1'b1, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0, rc, 3'd4};
  endfunction

  task automatic add(input bit r, input int n, input logic [1:0] en, input logic [1:0] lk,
                     input logic rq, input logic [12:0] e);
    vec_t v;
    v.do_rst = r; v.n = n; v.en = en; v.lock = lk; v.retry = rq; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [12:0] e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s got pll/gt/rdy/cr/fail/ll/rc/st=%b_%b_%b_%b_%b_%b_%b_%b want %b_%b_%b_%b_%b_%b_%b_%b",
               name, act[12], act[11:10], act[9:8], act[7], act[6], act[5], act[4:3], act[2:0],
               e[12], e[11:10], e[9:8], e[7], e[6], e[5], e[4:3], e[2:0]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Nominal bring-up, then lock loss in RUN (cycle numbers after rst release)
    add(1, 0,  2'b11, 2'b00, 0, s_hold(0, 0));      // reset state
    add(0, 7,  2'b11, 2'b00, 1, s_hold(0, 0));      // c7: still HOLD, retry_req ignored
    add(0, 1,  2'b11, 2'b00, 0, s_wait(0));         // c8: pll_reset drops
    add(0, 2,  2'b11, 2'b00, 0, s_wait(0));         // c10
    add(0, 3,  2'b11, 2'b11, 0, s_wait(0));         // c13: 4th locked cycle
    add(0, 1,  2'b11, 2'b11, 0, s_tx(0));           // c14
    add(0, 2,  2'b11, 2'b11, 0, s_tx(0));           // c16
    add(0, 1,  2'b11, 2'b11, 0, s_run(2'b00, 2'b11)); // c17
    add(0, 1,  2'b11, 2'b11, 0, s_run(2'b00, 2'b11)); // c18
    add(0, 1,  2'b11, 2'b10, 0, s_hold(0, 1));      // lane0 lost: pulse + HOLD
    add(0, 1,  2'b11, 2'b10, 0, s_hold(0, 0));      // pulse is one cycle
    // Lock glitch on lane1 during stability, then lock loss in TX_RST
    add(1, 8,  2'b11, 2'b00, 0, s_wait(0));         // c8
    add(0, 2,  2'b11, 2'b11, 0, s_wait(0));         // c10
    add(0, 1,  2'b11, 2'b01, 0, s_wait(0));         // c11 glitch
    add(0, 3,  2'b11, 2'b11, 0, s_wait(0));         // c14
    add(0, 1,  2'b11, 2'b11, 0, s_tx(0));           // c15
    add(0, 1,  2'b11, 2'b10, 0, s_hold(0, 0));      // TX_RST lock loss, no retry
    // Lane mask, then lane_en widening in RUN
    add(1, 8,  2'b01, 2'b01, 0, s_wait(0));
    add(0, 4,  2'b01, 2'b01, 0, s_tx(0));
    add(0, 3,  2'b01, 2'b01, 0, s_run(2'b10, 2'b01));
    add(0, 1,  2'b11, 2'b11, 0, s_run(2'b00, 2'b11));
    add(0, 1,  2'b11, 2'b01, 0, s_hold(0, 1));      // newly enabled lane1 unlocked
    // Timeout x2 -> FAIL -> retry_req
    add(1, 27, 2'b11, 2'b00, 0, s_wait(0));         // c27: last timeout cycle
    add(0, 1,  2'b11, 2'b00, 0, s_hold(1, 0));      // c28
    add(0, 27, 2'b11, 2'b00, 0, s_wait(1));         // c55
    add(0, 1,  2'b11, 2'b00, 0, s_fail(2));         // c56
    add(0, 3,  2'b11, 2'b11, 0, s_fail(2));         // stays in FAIL
    add(0, 1,  2'b11, 2'b11, 1, s_hold(0, 0));      // retry_req
    add(0, 1,  2'b11, 2'b11, 0, s_hold(0, 0));

    foreach (vecs[i]) begin
      lane_en   = vecs[i].en;
      pll_lock  = vecs[i].lock;
      retry_req = vecs[i].retry;
      if (vecs[i].do_rst) do_reset();
      repeat (vecs[i].n) @(posedge clk);
      if (vecs[i].n > 0) #1;
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Asynchronous reset between clock edges while in TX_RST
    lane_en = 2'b11; pll_lock = 2'b11; retry_req = 1'b0;
    do_reset();
    repeat (13) @(posedge clk);
    #1;
    check("async_pre_txrst", s_tx(0));
    #2 rst = 1'b1;
    #1;
    check("async_rst_no_edge", s_hold(0, 0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("async_after_release", s_hold(0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
